// File: rtl/accumulator_read_drain.sv
// Read-side drain controller for the partial-sum accumulator bank: waits out write skew,
// issues credit-limited row reads and streams captured rows to the consumer over valid/ready.
module accumulator_read_drain #(
    parameter int unsigned SYSTOLIC_SIZE     = 8,
    parameter int unsigned WEIGHT_WIDTH      = 8,
    parameter int unsigned ACTIVATION_WIDTH  = 8,
    parameter int unsigned PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int unsigned PATTERN_NUMBER    = 1,
    parameter int unsigned ADDR_WIDTH        = $clog2(PATTERN_NUMBER * SYSTOLIC_SIZE),
    parameter int unsigned RD_LATENCY        = 1,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          test_mode,
    input  logic [ADDR_WIDTH-1:0]                         base_addr,
    input  logic [ADDR_WIDTH:0]                           num_rows,
    output logic                                          busy,
    output logic                                          done,
    output logic [ADDR_WIDTH-1:0]                         rd_addr,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]    rd_data_flat,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]    out_data_flat,
    output logic [ADDR_WIDTH-1:0]                         out_addr,
    output logic                                          out_last
);

    localparam int unsigned DEPTH         = PATTERN_NUMBER * SYSTOLIC_SIZE;
    localparam int unsigned DATA_W        = PARTIAL_SUM_WIDTH * SYSTOLIC_SIZE;
    localparam int unsigned ROWS_W        = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned INF_W         = $clog2(RD_LATENCY + 1) + 1;
    localparam int unsigned SET_W         = $clog2(SYSTOLIC_SIZE) + 1;
    localparam int unsigned SETTLE_CYCLES = SYSTOLIC_SIZE - 1;
    localparam bit          NO_SETTLE     = (SETTLE_CYCLES == 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  busy_q, done_q;
    logic [ADDR_WIDTH-1:0] base_q, rd_addr_q;
    logic [ROWS_W-1:0]     rows_left_q;
    logic [SET_W-1:0]      settle_q;

    logic                  accept_c, enter_issue_c, finish_c;
    logic                  issue_c, last_issue_c, credit_c, drain_done_c;
    logic [ADDR_WIDTH-1:0] issue_base_c, next_addr_c;
    logic                  push_c, push_last_c, pop_c;
    logic [ADDR_WIDTH-1:0] push_addr_c;
    logic [INF_W-1:0]      inflight_c;

    logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  out_valid_q;

    assign credit_c     = (32'(count_q) + 32'(inflight_c)) < FIFO_DEPTH;
    assign issue_c      = (state_q == S_ISSUE) && credit_c;
    assign last_issue_c = issue_c && (rows_left_q == ROWS_W'(1));
    assign issue_base_c = (state_q == S_IDLE) ? base_addr : base_q;
    assign next_addr_c  = (rd_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
    assign pop_c        = out_valid_q && out_ready;
    assign drain_done_c = (inflight_c == '0) && !push_c &&
                          ((count_q == '0) || ((count_q == CNT_W'(1)) && pop_c));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d       = state_q;
        accept_c      = 1'b0;
        enter_issue_c = 1'b0;
        finish_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (num_rows == '0) begin
                        state_d = S_DRAIN;
                    end else if (test_mode || NO_SETTLE) begin
                        state_d       = S_ISSUE;
                        enter_issue_c = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d       = S_ISSUE;
                    enter_issue_c = 1'b1;
                end
            end
            S_ISSUE: begin
                if (last_issue_c) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done_c) begin
                    state_d  = S_IDLE;
                    finish_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job bookkeeping and read address; rd_addr stays on the last issued row after the final read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            base_q      <= '0;
            rows_left_q <= '0;
            settle_q    <= '0;
            rd_addr_q   <= '0;
        end else begin
            done_q <= finish_c;
            if (accept_c) begin
                busy_q      <= 1'b1;
                base_q      <= base_addr;
                rows_left_q <= num_rows;
                settle_q    <= '0;
            end else begin
                if (finish_c)             busy_q      <= 1'b0;
                if (state_q == S_SETTLE)  settle_q    <= settle_q + SET_W'(1);
                if (issue_c)              rows_left_q <= rows_left_q - ROWS_W'(1);
            end
            if (enter_issue_c)                       rd_addr_q <= issue_base_c;
            else if (issue_c && !last_issue_c)       rd_addr_q <= next_addr_c;
        end
    end

    // Tag pipeline aligning row address / last flag with returning read data
    if (RD_LATENCY == 0) begin : g_lat0
        assign push_c      = issue_c;
        assign push_addr_c = rd_addr_q;
        assign push_last_c = last_issue_c;
        assign inflight_c  = '0;
    end else begin : g_lat
        logic [RD_LATENCY-1:0] tag_vld_q;
        logic [RD_LATENCY-1:0] tag_last_q;
        logic [ADDR_WIDTH-1:0] tag_addr_q [RD_LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_vld_q  <= '0;
                tag_last_q <= '0;
                for (int i = 0; i < int'(RD_LATENCY); i++) tag_addr_q[i] <= '0;
            end else begin
                tag_vld_q[0]  <= issue_c;
                tag_last_q[0] <= last_issue_c;
                tag_addr_q[0] <= rd_addr_q;
                for (int i = 1; i < int'(RD_LATENCY); i++) begin
                    tag_vld_q[i]  <= tag_vld_q[i-1];
                    tag_last_q[i] <= tag_last_q[i-1];
                    tag_addr_q[i] <= tag_addr_q[i-1];
                end
            end
        end

        assign push_c      = tag_vld_q[RD_LATENCY-1];
        assign push_addr_c = tag_addr_q[RD_LATENCY-1];
        assign push_last_c = tag_last_q[RD_LATENCY-1];

        always_comb begin
            inflight_c = '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) inflight_c = inflight_c + INF_W'(tag_vld_q[i]);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Output FIFO; credit check upstream keeps it from overflowing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                fifo_data_q[wr_ptr_q] <= rd_data_flat;
                fifo_addr_q[wr_ptr_q] <= push_addr_c;
                fifo_last_q[wr_ptr_q] <= push_last_c;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_q     <= count_d;
            out_valid_q <= (count_d != '0);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign rd_addr       = rd_addr_q;
    assign out_valid     = out_valid_q;
    assign out_data_flat = fifo_data_q[rd_ptr_q];
    assign out_addr      = fifo_addr_q[rd_ptr_q];
    assign out_last      = fifo_last_q[rd_ptr_q];

endmodule
